mmio_irq_timer: RTL and testbench



---
 rtl/mmio_irq_timer.sv | 161 ++++++++++++++++
 tb/tb_mmio_irq_timer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_irq_timer.sv
// mmio_irq_timer: MMIO-programmable countdown timer and level interrupt source.
// Drives mmio_BInterrupt06, which is forwarded to the core's BInterrupt06 pin.
// Register window (word addresses):
//   0 CTRL   [0] IE, [1] RUN          RW
//   1 LOAD   CNT_W bits               RW
//   2 COUNT  current counter          RO
//   3 STATUS [0] PEND                 W1C
//   4 SWSET  [0]=1 sets PEND          WO (reads 0)
//   5..7     reads 0, writes ignored
// Build option: define MMIO_IRQ_TIMER_AUTO_RELOAD_EN for periodic mode
// (reload from LOAD on expiry). The default build is one-shot, and RUN
// self-clears on expiry.
module mmio_irq_timer #(
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              BReset_n,
  input  logic              mmio_wr,
  input  logic              mmio_rd,
  input  logic [ADDR_W-1:0] mmio_addr,
  input  logic [31:0]       mmio_wdata,
  output logic [31:0]       mmio_rdata,
  output logic              mmio_BInterrupt06
);

  typedef enum logic {S_IDLE, S_COUNT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ie;
  logic             r_run;
  logic             r_pend;
  logic [CNT_W-1:0] r_load;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_rdata;
  logic             r_irq;

  logic             w_wr_ctrl;
  logic             w_wr_load;
  logic             w_wr_status;
  logic             w_wr_swset;
  logic [CNT_W-1:0] w_load_eff;
  logic             w_expire;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_run_nxt;
  logic             w_pend_nxt;
  logic [31:0]      w_rdata_nxt;

  assign w_wr_ctrl   = mmio_wr && (mmio_addr == ADDR_W'(0));
  assign w_wr_load   = mmio_wr && (mmio_addr == ADDR_W'(1));
  assign w_wr_status = mmio_wr && (mmio_addr == ADDR_W'(3));
  assign w_wr_swset  = mmio_wr && (mmio_addr == ADDR_W'(4));

  // A LOAD of 0 behaves like 1 so a started timer always expires.
  assign w_load_eff = (r_load == '0) ? CNT_W'(1) : r_load;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK or negedge BReset_n) begin
    if (!BReset_n) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next-state logic: CTRL writes dominate; otherwise expiry ends or reloads.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_wr_ctrl && mmio_wdata[1]) w_state_nxt = S_COUNT;
      end
      S_COUNT: begin
        if (w_wr_ctrl) begin
          w_state_nxt = mmio_wdata[1] ? S_COUNT : S_IDLE;
        end else if (r_count == CNT_W'(1)) begin
`ifdef MMIO_IRQ_TIMER_AUTO_RELOAD_EN
          w_state_nxt = S_COUNT;
`else
          w_state_nxt = S_IDLE;
`endif
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: counter, RUN and PEND updates plus the read-data mux.
  always_comb begin
    // A CTRL write on the terminal edge restarts or stops instead of expiring.
    w_expire    = (r_state == S_COUNT) && !w_wr_ctrl && (r_count == CNT_W'(1));
    w_count_nxt = r_count;
    w_run_nxt   = r_run;
    w_pend_nxt  = r_pend;

    if (w_wr_ctrl) begin
      w_run_nxt = mmio_wdata[1];
      // Start or restart loads the counter; stop leaves it frozen.
      if (mmio_wdata[1]) w_count_nxt = w_load_eff;
    end else if (r_state == S_COUNT) begin
      if (w_expire) begin
`ifdef MMIO_IRQ_TIMER_AUTO_RELOAD_EN
        w_count_nxt = w_load_eff;
`else
        w_count_nxt = '0;
        w_run_nxt   = 1'b0;
`endif
      end else if (r_count != '0) begin
        w_count_nxt = r_count - CNT_W'(1);
      end
    end

    // Clear first so a simultaneous set (expiry or SWSET) wins.
    if (w_wr_status && mmio_wdata[0]) w_pend_nxt = 1'b0;
    if (w_expire || (w_wr_swset && mmio_wdata[0])) w_pend_nxt = 1'b1;

    w_rdata_nxt = '0;
    unique case (mmio_addr)
      ADDR_W'(0): w_rdata_nxt = {30'd0, r_run, r_ie};
      ADDR_W'(1): w_rdata_nxt = 32'(r_load);
      ADDR_W'(2): w_rdata_nxt = 32'(r_count);
      ADDR_W'(3): w_rdata_nxt = {31'd0, r_pend};
      default:    w_rdata_nxt = '0;
    endcase
  end

  // Architectural registers.
  always_ff @(posedge CLK or negedge BReset_n) begin
    if (!BReset_n) begin
      r_ie    <= 1'b0;
      r_run   <= 1'b0;
      r_pend  <= 1'b0;
      r_load  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_ctrl) r_ie <= mmio_wdata[0];
      if (w_wr_load) r_load <= mmio_wdata[CNT_W-1:0];
      r_run   <= w_run_nxt;
      r_pend  <= w_pend_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Registered read data: captures pre-write contents and holds when idle.
  always_ff @(posedge CLK or negedge BReset_n) begin
    if (!BReset_n)    r_rdata <= '0;
    else if (mmio_rd) r_rdata <= w_rdata_nxt;
  end

  // Registered level interrupt, one cycle behind PEND and IE.
  always_ff @(posedge CLK or negedge BReset_n) begin
    if (!BReset_n) r_irq <= 1'b0;
    else           r_irq <= r_pend & r_ie;
  end

  assign mmio_rdata        = r_rdata;
  assign mmio_BInterrupt06 = r_irq;

endmodule

// File: tb/tb_mmio_irq_timer.sv
// Directed bench for mmio_irq_timer. Expected values are hand-derived edge
// by edge; builds with MMIO_IRQ_TIMER_AUTO_RELOAD_EN select the periodic
// expectations where the two modes differ.
module tb_mmio_irq_timer;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_LOAD   = 3'd1;
  localparam logic [2:0] A_COUNT  = 3'd2;
  localparam logic [2:0] A_STATUS = 3'd3;
  localparam logic [2:0] A_SWSET  = 3'd4;

`ifdef MMIO_IRQ_TIMER_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        CLK;
  logic        BReset_n;
  logic        mmio_wr;
  logic        mmio_rd;
  logic [2:0]  mmio_addr;
  logic [31:0] mmio_wdata;
  logic [31:0] mmio_rdata;
  logic        mmio_BInterrupt06;

  int total;
  int bad;

  mmio_irq_timer #(.CNT_W(32), .ADDR_W(3)) dut (
    .CLK               (CLK),
    .BReset_n          (BReset_n),
    .mmio_wr           (mmio_wr),
    .mmio_rd           (mmio_rd),
    .mmio_addr         (mmio_addr),
    .mmio_wdata        (mmio_wdata),
    .mmio_rdata        (mmio_rdata),
    .mmio_BInterrupt06 (mmio_BInterrupt06)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each helper consumes one rising edge and returns 1 ns after it.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    mmio_wr    = 1'b1;
    mmio_addr  = a;
    mmio_wdata = d;
    step(1);
    mmio_wr    = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
    mmio_rd   = 1'b1;
    mmio_addr = a;
    step(1);
    mmio_rd   = 1'b0;
    check(tag, mmio_rdata, exp);
  endtask

  task automatic irq_check(input string tag, input logic exp);
    check(tag, {31'd0, mmio_BInterrupt06}, {31'd0, exp});
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    BReset_n   = 1'b0;
    mmio_wr    = 1'b0;
    mmio_rd    = 1'b0;
    mmio_addr  = '0;
    mmio_wdata = '0;

    // Reset state
    #7;
    check("rst_rdata", mmio_rdata, 32'd0);
    irq_check("rst_irq", 1'b0);
    @(negedge CLK);
    BReset_n = 1'b1;
    step(1);
    rd_check("rst_ctrl",   A_CTRL,   32'd0);
    rd_check("rst_load",   A_LOAD,   32'd0);
    rd_check("rst_count",  A_COUNT,  32'd0);
    rd_check("rst_status", A_STATUS, 32'd0);

    // One-shot LOAD=5: start at t0, PEND at t0+5, interrupt at t0+6
    wr(A_LOAD, 32'd5);
    wr(A_CTRL, 32'd3);                         // t0
    rd_check("os_count_t1", A_COUNT, 32'd5);   // t0+1 samples 5
    step(4);                                   // t0+5, PEND sets here
    irq_check("os_irq_t5", 1'b0);
    rd_check("os_pend_t6", A_STATUS, 32'd1);   // t0+6
    irq_check("os_irq_t6", 1'b1);
    rd_check("os_ctrl", A_CTRL, AUTO ? 32'd3 : 32'd1);  // t0+7
    rd_check("os_count_end", A_COUNT, AUTO ? 32'd3 : 32'd0); // t0+8
    wr(A_CTRL, 32'd1);                         // stop (no-op when one-shot)
    wr(A_STATUS, 32'd1);                       // W1C
    irq_check("w1c_irq_same", 1'b1);
    step(1);
    irq_check("w1c_irq_next", 1'b0);

    // LOAD=0 behaves as 1
    wr(A_LOAD, 32'd0);
    wr(A_CTRL, 32'd3);                         // t0
    step(1);                                   // t0+1 PEND sets
    rd_check("load0_pend", A_STATUS, 32'd1);
    wr(A_CTRL, 32'd0);
    wr(A_STATUS, 32'd1);
    rd_check("load0_clr", A_STATUS, 32'd0);

    // IE=0 masks the interrupt; enabling IE raises it one cycle later
    wr(A_CTRL, 32'd2);
    step(2);
    irq_check("ie0_irq", 1'b0);
    rd_check("ie0_pend", A_STATUS, 32'd1);
    wr(A_CTRL, 32'd1);
    irq_check("ie1_irq_same", 1'b0);
    step(1);
    irq_check("ie1_irq_next", 1'b1);
    wr(A_STATUS, 32'd1);
    step(1);
    irq_check("ie1_irq_clr", 1'b0);

    // Stop at COUNT=4 then restart from LOAD=10
    wr(A_LOAD, 32'd10);
    wr(A_CTRL, 32'd3);                         // t0, COUNT=10
    step(6);                                   // COUNT=4 after t0+6
    wr(A_CTRL, 32'd0);                         // t0+7 stops, COUNT holds 4
    step(20);
    rd_check("stop_count", A_COUNT, 32'd4);
    rd_check("stop_pend", A_STATUS, 32'd0);
    irq_check("stop_irq", 1'b0);
    wr(A_CTRL, 32'd3);                         // s0
    rd_check("restart_count", A_COUNT, 32'd10); // s0+1
    wr(A_LOAD, 32'd3);                         // s0+2, COUNT=8 after
    rd_check("load_midcount", A_COUNT, 32'd8); // s0+3
    step(6);                                   // s0+9, COUNT=1
    rd_check("pre_expire", A_STATUS, 32'd0);   // s0+10 expiry edge
    rd_check("post_expire", A_STATUS, 32'd1);  // s0+11

    // Collision: W1C on the expiry edge keeps PEND set
    wr(A_CTRL, 32'd1);
    wr(A_STATUS, 32'd1);
    wr(A_CTRL, 32'd3);                         // t0, LOAD=3
    step(2);                                   // t0+2, COUNT=1
    wr(A_STATUS, 32'd1);                       // t0+3 expiry + W1C
    rd_check("collide_pend", A_STATUS, 32'd1);
    wr(A_CTRL, 32'd1);
    wr(A_STATUS, 32'd1);
    rd_check("collide_clr", A_STATUS, 32'd0);
    irq_check("collide_irq", 1'b0);

    // SWSET while idle with IE=1, and unmapped addresses
    wr(A_SWSET, 32'd1);
    irq_check("swset_irq_same", 1'b0);
    step(1);
    irq_check("swset_irq_next", 1'b1);
    wr(3'd6, 32'hFFFF_FFFF);                   // ignored
    rd_check("rd_swset", A_SWSET, 32'd0);
    rd_check("rd_addr5", 3'd5, 32'd0);
    rd_check("rd_addr6", 3'd6, 32'd0);
    rd_check("ctrl_after_a6", A_CTRL, 32'd1);
    wr(A_STATUS, 32'd1);
    step(1);

    // Periodic vs one-shot with LOAD=3 and a clear between expiries
    wr(A_CTRL, 32'd3);                         // t0
    step(3);                                   // t0+3 first expiry
    irq_check("per_irq_t3", 1'b0);
    wr(A_STATUS, 32'd1);                       // t0+4
    irq_check("per_irq_t4", 1'b1);
    step(1);                                   // t0+5
    irq_check("per_irq_t5", 1'b0);
    step(1);                                   // t0+6 second expiry (auto)
    wr(A_STATUS, 32'd1);                       // t0+7
    irq_check("per_irq_t7", AUTO);
    step(1);                                   // t0+8
    irq_check("per_irq_t8", 1'b0);
    step(1);                                   // t0+9 third expiry (auto)
    wr(A_STATUS, 32'd1);                       // t0+10
    irq_check("per_irq_t10", AUTO);
    rd_check("per_ctrl", A_CTRL, AUTO ? 32'd3 : 32'd1);

    // Asynchronous reset mid-operation
    wr(A_SWSET, 32'd1);
    step(1);
    irq_check("prerst_irq", 1'b1);
    #3;
    BReset_n = 1'b0;
    #1;
    irq_check("async_rst_irq", 1'b0);
    check("async_rst_rdata", mmio_rdata, 32'd0);
    @(negedge CLK);
    BReset_n = 1'b1;
    step(3);
    rd_check("post_rst_ctrl",   A_CTRL,   32'd0);
    rd_check("post_rst_load",   A_LOAD,   32'd0);
    rd_check("post_rst_count",  A_COUNT,  32'd0);
    rd_check("post_rst_status", A_STATUS, 32'd0);
    irq_check("post_rst_irq", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
